// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, legal prescale ratios and
// parity-type constants used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  function automatic logic is_legal_prescale(input logic [5:0] p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

  // Parity bit the sender should have put on the line, given the XOR of the data bits.
  function automatic logic expected_parity(input logic data_xor, input logic par_typ);
    return (par_typ == EVEN) ? data_xor : ~data_xor;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// UART receiver signal bundle: serial line and frame configuration in,
// recovered word and status strobes out.
interface uart_rx_if #(
  parameter int WIDTH = 8
);
  logic             RX_IN;
  logic [5:0]       Prescale;
  logic             PAR_EN;
  logic             PAR_TYP;
  logic [WIDTH-1:0] P_DATA;
  logic             DATA_VALID;
  logic             PAR_ERR;
  logic             STP_ERR;

  modport master (
    output RX_IN, Prescale, PAR_EN, PAR_TYP,
    input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );

  modport slave (
    input  RX_IN, Prescale, PAR_EN, PAR_TYP,
    output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-sample majority voter for the UART receiver.
// The counter is held at 0 while i_run is low and wraps at prescale-1.
module uart_rx_sampler (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_run,
  input  logic       i_rx,
  input  logic [5:0] i_prescale,
  output logic [5:0] o_edge_cnt,
  output logic       o_sampled_bit,
  output logic       o_bit_done
);

  logic [5:0] r_edge_cnt;
  logic [2:0] r_samples;
  logic [5:0] w_half;
  logic [5:0] w_last;

  assign w_half = i_prescale >> 1;
  assign w_last = i_prescale - 6'd1;

  always_ff @(posedge CLK) begin
    if (!RST || !i_run) begin
      r_edge_cnt <= '0;
    end else if (r_edge_cnt == w_last) begin
      r_edge_cnt <= '0;
    end else begin
      r_edge_cnt <= r_edge_cnt + 6'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_samples <= '1;
    end else if (i_run) begin
      if (r_edge_cnt == w_half - 6'd1) r_samples[0] <= i_rx;
      if (r_edge_cnt == w_half)        r_samples[1] <= i_rx;
      if (r_edge_cnt == w_half + 6'd1) r_samples[2] <= i_rx;
    end
  end

  assign o_edge_cnt    = r_edge_cnt;
  assign o_sampled_bit = (r_samples[0] & r_samples[1]) |
                         (r_samples[0] & r_samples[2]) |
                         (r_samples[1] & r_samples[2]);
  assign o_bit_done    = i_run && (r_edge_cnt == w_last);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start/data/parity/stop framing with 1-cycle status strobes.
// Define UART_RX_INPUT_SYNC_EN to pass RX_IN through a 2-flop synchronizer first.
module uart_rx
  import uart_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic        CLK,
  input logic        RST,
  uart_rx_if.slave   rx_if
);

  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  rx_state_t        r_state, w_next_state;
  logic [5:0]       r_prescale;
  logic             r_par_en;
  logic             r_par_typ;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_p_data;
  logic [BCW-1:0]   r_bit_cnt, w_bit_cnt_next;
  logic             r_par_bad;
  logic             r_data_valid, r_par_err, r_stp_err;

  logic             w_rx;
  logic [5:0]       w_edge_cnt;
  logic             w_sampled_bit;
  logic             w_bit_done;
  logic             w_start_det, w_shift_en, w_par_chk, w_eval;

`ifdef UART_RX_INPUT_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge CLK) begin
    if (!RST) r_sync <= '1;
    else      r_sync <= {r_sync[0], rx_if.RX_IN};
  end

  assign w_rx = r_sync[1];
`else
  assign w_rx = rx_if.RX_IN;
`endif

  uart_rx_sampler u_sampler (
    .CLK           (CLK),
    .RST           (RST),
    .i_run         (r_state != IDLE),
    .i_rx          (w_rx),
    .i_prescale    (r_prescale),
    .o_edge_cnt    (w_edge_cnt),
    .o_sampled_bit (w_sampled_bit),
    .o_bit_done    (w_bit_done)
  );

  always_ff @(posedge CLK) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_start_det    = 1'b0;
    w_shift_en     = 1'b0;
    w_par_chk      = 1'b0;
    w_eval         = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rx) begin
          w_next_state = START;
          w_start_det  = 1'b1;
        end
      end
      START: begin
        w_bit_cnt_next = '0;
        if (w_bit_done) w_next_state = w_sampled_bit ? IDLE : DATA;
      end
      DATA: begin
        if (w_bit_done) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == BCW'(WIDTH - 1)) begin
            w_bit_cnt_next = '0;
            w_next_state   = r_par_en ? PARITY : STOP;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        // Majority result first becomes valid two counts past mid-bit.
        w_par_chk = (w_edge_cnt == (r_prescale >> 1) + 6'd2);
        if (w_bit_done) w_next_state = STOP;
      end
      STOP: begin
        if (w_bit_done) begin
          w_eval       = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_prescale   <= PRESCALE_16;
      r_par_en     <= 1'b0;
      r_par_typ    <= EVEN;
      r_shift      <= '0;
      r_p_data     <= '0;
      r_bit_cnt    <= '0;
      r_par_bad    <= 1'b0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
      r_bit_cnt    <= w_bit_cnt_next;
      if (w_start_det) begin
        // Illegal ratios fall back to 16 so a stray setting still frames sanely.
        r_prescale <= is_legal_prescale(rx_if.Prescale) ? rx_if.Prescale : PRESCALE_16;
        r_par_en   <= rx_if.PAR_EN;
        r_par_typ  <= rx_if.PAR_TYP;
        r_par_bad  <= 1'b0;
      end
      if (w_shift_en) r_shift <= {w_sampled_bit, r_shift[WIDTH-1:1]};
      if (w_par_chk)  r_par_bad <= (w_sampled_bit != expected_parity(^r_shift, r_par_typ));
      if (w_eval) begin
        r_stp_err <= ~w_sampled_bit;
        r_par_err <= r_par_bad;
        if (w_sampled_bit && !r_par_bad) begin
          r_p_data     <= r_shift;
          r_data_valid <= 1'b1;
        end
      end
    end
  end

  assign rx_if.P_DATA     = r_p_data;
  assign rx_if.DATA_VALID = r_data_valid;
  assign rx_if.PAR_ERR    = r_par_err;
  assign rx_if.STP_ERR    = r_stp_err;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed framing cases plus randomized frames
// scored against a frame-level reference model.
module tb_uart_rx;

`ifdef UART_RX_INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_if #(.WIDTH(8)) rx_if ();

  uart_rx #(.WIDTH(8)) dut (
    .CLK   (clk),
    .RST   (rst),
    .rx_if (rx_if)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int         vcyc_q[$];
  logic [7:0] vdat_q[$];
  int         par_q[$];
  int         stp_q[$];

  logic [7:0] exp_pdata;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rx_if.DATA_VALID === 1'b1) begin
      vcyc_q.push_back(cyc);
      vdat_q.push_back(rx_if.P_DATA);
    end
    if (rx_if.PAR_ERR === 1'b1) par_q.push_back(cyc);
    if (rx_if.STP_ERR === 1'b1) stp_q.push_back(cyc);
  end

  task automatic clear_mon();
    vcyc_q.delete();
    vdat_q.delete();
    par_q.delete();
    stp_q.delete();
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx_if.RX_IN = 1'b1;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int p);
    @(negedge clk);
    rx_if.RX_IN = b;
    repeat (p - 1) @(negedge clk);
  endtask

  // Drives one whole frame; when scramble is set, config inputs change right after the start edge.
  task automatic send_frame(input logic [7:0] d, input int p, input logic pen, input logic ptyp,
                            input logic pbit, input logic sbit, input logic scramble,
                            output int start_cyc);
    rx_if.Prescale = 6'(p);
    rx_if.PAR_EN   = pen;
    rx_if.PAR_TYP  = ptyp;
    @(negedge clk);
    rx_if.RX_IN = 1'b0;
    start_cyc = cyc + 1;
    for (int i = 0; i < p - 1; i++) begin
      @(negedge clk);
      if (scramble && i == 0) begin
        rx_if.Prescale = 6'($urandom_range(0, 63));
        rx_if.PAR_EN   = 1'($urandom);
        rx_if.PAR_TYP  = 1'($urandom);
      end
    end
    for (int b = 0; b < 8; b++) send_bit(d[b], p);
    if (pen) send_bit(pbit, p);
    send_bit(sbit, p);
  endtask

  function automatic logic model_par(input logic [7:0] d, input logic ptyp);
    int ones;
    ones = $countones(d);
    return ptyp ? logic'((ones + 1) % 2) : logic'(ones % 2);
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (rx_if.P_DATA !== 8'h00) $display("FAIL reset_pdata got=%h exp=00", rx_if.P_DATA);
    else n_pass++;
    n_checks++;
    if ({rx_if.DATA_VALID, rx_if.PAR_ERR, rx_if.STP_ERR} !== 3'b000)
      $display("FAIL reset_strobes got=%b exp=000", {rx_if.DATA_VALID, rx_if.PAR_ERR, rx_if.STP_ERR});
    else n_pass++;
    rst = 1'b1;
    exp_pdata = 8'h00;
    idle(4);
  endtask

  task automatic test_directed();
    int s;
    clear_mon();
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, s);
    idle(6);
    n_checks++;
    if (vcyc_q.size() !== 1) $display("FAIL a5_valid_count got=%0d exp=1", vcyc_q.size());
    else n_pass++;
    if (vcyc_q.size() == 1) begin
      n_checks++;
      if (vdat_q[0] !== 8'hA5) $display("FAIL a5_pdata got=%h exp=a5", vdat_q[0]);
      else n_pass++;
      n_checks++;
      if (vcyc_q[0] - s !== 88 + LAT) $display("FAIL a5_latency got=%0d exp=%0d", vcyc_q[0] - s, 88 + LAT);
      else n_pass++;
    end
    n_checks++;
    if (par_q.size() + stp_q.size() !== 0) $display("FAIL a5_errors got=%0d exp=0", par_q.size() + stp_q.size());
    else n_pass++;
    exp_pdata = 8'hA5;

    clear_mon();
    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, s);
    idle(6);
    n_checks++;
    if ({par_q.size(), vcyc_q.size(), stp_q.size()} !== {32'd1, 32'd0, 32'd0})
      $display("FAIL 3c_pulses got par=%0d valid=%0d stp=%0d exp par=1 valid=0 stp=0",
               par_q.size(), vcyc_q.size(), stp_q.size());
    else n_pass++;
    n_checks++;
    if (rx_if.P_DATA !== exp_pdata) $display("FAIL 3c_pdata_held got=%h exp=%h", rx_if.P_DATA, exp_pdata);
    else n_pass++;

    clear_mon();
    send_frame(8'h81, 32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s);
    idle(6);
    n_checks++;
    if ({stp_q.size(), vcyc_q.size(), par_q.size()} !== {32'd1, 32'd0, 32'd0})
      $display("FAIL 81_stop_pulses got stp=%0d valid=%0d par=%0d exp stp=1 valid=0 par=0",
               stp_q.size(), vcyc_q.size(), par_q.size());
    else n_pass++;
    clear_mon();
    send_frame(8'h81, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s);
    idle(6);
    exp_pdata = 8'h81;
    n_checks++;
    if (vcyc_q.size() !== 1 || rx_if.P_DATA !== exp_pdata)
      $display("FAIL 81_good got valid=%0d pdata=%h exp valid=1 pdata=81", vcyc_q.size(), rx_if.P_DATA);
    else n_pass++;
  endtask

  task automatic test_glitch();
    int s;
    clear_mon();
    rx_if.Prescale = 6'd16;
    rx_if.PAR_EN   = 1'b0;
    @(negedge clk);
    rx_if.RX_IN = 1'b0;
    repeat (2) @(negedge clk);
    idle(60);
    n_checks++;
    if (vcyc_q.size() + par_q.size() + stp_q.size() !== 0)
      $display("FAIL glitch_pulses got=%0d exp=0", vcyc_q.size() + par_q.size() + stp_q.size());
    else n_pass++;
    send_frame(8'h6B, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s);
    idle(6);
    exp_pdata = 8'h6B;
    n_checks++;
    if (vcyc_q.size() !== 1 || rx_if.P_DATA !== exp_pdata)
      $display("FAIL glitch_recover got valid=%0d pdata=%h exp valid=1 pdata=6b", vcyc_q.size(), rx_if.P_DATA);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int s0, s1;
    clear_mon();
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s0);
    send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s1);
    idle(8);
    n_checks++;
    if (vcyc_q.size() !== 2) $display("FAIL b2b_count got=%0d exp=2", vcyc_q.size());
    else n_pass++;
    if (vcyc_q.size() == 2) begin
      n_checks++;
      if (vcyc_q[1] - vcyc_q[0] < 79 || vcyc_q[1] - vcyc_q[0] > 81)
        $display("FAIL b2b_spacing got=%0d exp=80+/-1", vcyc_q[1] - vcyc_q[0]);
      else n_pass++;
      n_checks++;
      if ({vdat_q[0], vdat_q[1]} !== 16'h00FF) $display("FAIL b2b_data got=%h%h exp=00ff", vdat_q[0], vdat_q[1]);
      else n_pass++;
    end
    exp_pdata = 8'hFF;
  endtask

  task automatic test_reset_mid();
    int s;
    logic [7:0] d;
    d = 8'h55;
    clear_mon();
    rx_if.Prescale = 6'd8;
    rx_if.PAR_EN   = 1'b0;
    @(negedge clk);
    rx_if.RX_IN = 1'b0;
    repeat (7) @(negedge clk);
    for (int b = 0; b < 4; b++) send_bit(d[b], 8);
    @(negedge clk);
    rx_if.RX_IN = d[4];
    repeat (3) @(negedge clk);
    n_checks++;
    if (rx_if.P_DATA !== exp_pdata) $display("FAIL rstmid_pre_pdata got=%h exp=%h", rx_if.P_DATA, exp_pdata);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({rx_if.P_DATA, rx_if.DATA_VALID, rx_if.PAR_ERR, rx_if.STP_ERR} !== 11'h000)
      $display("FAIL rstmid_outputs got=%h exp=000",
               {rx_if.P_DATA, rx_if.DATA_VALID, rx_if.PAR_ERR, rx_if.STP_ERR});
    else n_pass++;
    rst = 1'b1;
    exp_pdata = 8'h00;
    idle(100);
    n_checks++;
    if (vcyc_q.size() + par_q.size() + stp_q.size() !== 0)
      $display("FAIL rstmid_silent got=%0d exp=0", vcyc_q.size() + par_q.size() + stp_q.size());
    else n_pass++;
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s);
    idle(6);
    exp_pdata = 8'h55;
    n_checks++;
    if (vcyc_q.size() !== 1 || rx_if.P_DATA !== exp_pdata)
      $display("FAIL rstmid_next got valid=%0d pdata=%h exp valid=1 pdata=55", vcyc_q.size(), rx_if.P_DATA);
    else n_pass++;
  endtask

  task automatic test_line_low();
    clear_mon();
    rx_if.Prescale = 6'd8;
    rx_if.PAR_EN   = 1'b0;
    @(negedge clk);
    rx_if.RX_IN = 1'b0;
    repeat (160) @(negedge clk);
    idle(40);
    n_checks++;
    if ({stp_q.size(), vcyc_q.size(), par_q.size()} !== {32'd2, 32'd0, 32'd0})
      $display("FAIL line_low got stp=%0d valid=%0d par=%0d exp stp=2 valid=0 par=0",
               stp_q.size(), vcyc_q.size(), par_q.size());
    else n_pass++;
  endtask

  task automatic test_random();
    int s, p, nbits;
    logic [7:0] d;
    logic pen, ptyp, bad_par, bad_stop, pbit, exp_valid;
    for (int k = 0; k < 24; k++) begin
      d        = 8'($urandom);
      p        = 8 << $urandom_range(0, 2);
      pen      = 1'($urandom);
      ptyp     = 1'($urandom);
      bad_par  = ($urandom_range(0, 3) == 0);
      bad_stop = ($urandom_range(0, 3) == 0);
      pbit     = model_par(d, ptyp) ^ bad_par;
      nbits    = pen ? 11 : 10;
      exp_valid = !bad_stop && !(pen && bad_par);
      clear_mon();
      send_frame(d, p, pen, ptyp, pbit, !bad_stop, 1'b1, s);
      idle($urandom_range(6, 9));
      if (exp_valid) exp_pdata = d;
      n_checks++;
      if (vcyc_q.size() !== int'(exp_valid))
        $display("FAIL rnd%0d_valid got=%0d exp=%0d", k, vcyc_q.size(), exp_valid);
      else n_pass++;
      n_checks++;
      if (par_q.size() !== int'(pen && bad_par))
        $display("FAIL rnd%0d_par_err got=%0d exp=%0d", k, par_q.size(), pen && bad_par);
      else n_pass++;
      n_checks++;
      if (stp_q.size() !== int'(bad_stop))
        $display("FAIL rnd%0d_stp_err got=%0d exp=%0d", k, stp_q.size(), bad_stop);
      else n_pass++;
      n_checks++;
      if (rx_if.P_DATA !== exp_pdata) $display("FAIL rnd%0d_pdata got=%h exp=%h", k, rx_if.P_DATA, exp_pdata);
      else n_pass++;
      if (exp_valid && vcyc_q.size() == 1) begin
        n_checks++;
        if (vcyc_q[0] - s !== nbits * p + LAT)
          $display("FAIL rnd%0d_latency got=%0d exp=%0d", k, vcyc_q[0] - s, nbits * p + LAT);
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst            = 1'b0;
    rx_if.RX_IN    = 1'b1;
    rx_if.Prescale = 6'd8;
    rx_if.PAR_EN   = 1'b0;
    rx_if.PAR_TYP  = 1'b0;
    exp_pdata      = 8'h00;
    test_reset();
    test_directed();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_line_low();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
